// File: rtl/mem_ctrl_pkg.sv
// Shared encodings for the byte-serial RAM sequencer.
// Access sizes, FSM states and the IO region tag.
package mem_ctrl_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  localparam logic [1:0] IO_ADDR_HI_DEF = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2
  } state_t;

  // Size code 3 is treated as a full word.
  function automatic logic [2:0] size_bytes(input logic [1:0] sz);
    case (sz)
      SZ_B:    return 3'd1;
      SZ_H:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_load_ext.sv
// Load result shaping: keeps the low bytes of a little-endian word
// and sign- or zero-extends them according to the access size.
module mem_load_ext
  import mem_ctrl_pkg::*;
(
  input  logic [31:0] raw,
  input  logic [1:0]  size,
  input  logic        sgn,
  output logic [31:0] data
);

  always_comb begin
    data = raw;
    case (size)
      SZ_B:    data = {{24{sgn & raw[7]}}, raw[7:0]};
      SZ_H:    data = {{16{sgn & raw[15]}}, raw[15:0]};
      default: data = raw;
    endcase
  end

endmodule

// File: rtl/mem_ctrl.sv
// Byte-serial RAM arbiter between instruction fetch and the store/load
// buffer; drives one 8-bit RAM port and returns a single done pulse.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int         ENTRY_W    = 4,
  parameter logic [1:0] IO_ADDR_HI = IO_ADDR_HI_DEF
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               rdy_in,
  input  logic               clear_in,
  input  logic               if_req,
  input  logic [31:0]        if_addr,
  output logic               if_done,
  output logic [31:0]        if_data,
  input  logic               slb_need,
  input  logic               slb_wr,
  input  logic [31:0]        slb_addr,
  input  logic [1:0]         slb_size,
  input  logic               slb_signed,
  input  logic [31:0]        slb_dout,
  input  logic [ENTRY_W-1:0] slb_entry,
  output logic               slb_done,
  output logic [ENTRY_W-1:0] slb_entry_out,
  output logic [31:0]        slb_din,
  input  logic [7:0]         mem_din,
  output logic [7:0]         mem_dout,
  output logic [31:0]        mem_a,
  output logic               mem_wr,
  input  logic               io_buffer_full
);

  state_t state, state_n;

  logic               last_slb;
  logic               is_fetch;
  logic [31:0]        req_addr;
  logic [31:0]        req_data;
  logic [2:0]         req_n;
  logic [1:0]         req_size;
  logic               req_sgn;
  logic [ENTRY_W-1:0] req_entry;
  logic [2:0]         step;
  logic [31:0]        raw_q;
  logic [31:0]        raw_n;
  logic [31:0]        ext_data;
  logic               wr_q;

  logic        can_acc;
  logic        grant_if;
  logic        grant_slb;
  logic        rd_last;
  logic        wr_last;
  logic        stall;
  logic        new_stall;
  logic [2:0]  step_p1;
  logic [31:0] addr_nxt;
  logic [7:0]  byte_nxt;
  logic [1:0]  lane;

  // Requesters drop their request in the cycle they see done,
  // so nothing is accepted while a pulse is on the wire.
  assign can_acc   = (state == ST_IDLE) && !if_done
                     && !slb_done && !clear_in;
  assign grant_if  = can_acc && if_req
                     && (!slb_need || last_slb);
  assign grant_slb = can_acc && slb_need && !grant_if;

  assign step_p1  = step + 3'd1;
  assign addr_nxt = req_addr + {29'd0, step_p1};
  assign byte_nxt = req_data[{step_p1[1:0], 3'b000} +: 8];
  assign lane     = step[1:0] - 2'd1;

  assign rd_last = (state == ST_READ) && (step == req_n);
  assign wr_last = (state == ST_WRITE) && wr_q
                   && (step_p1 == req_n);

  assign stall     = (req_addr[17:16] == IO_ADDR_HI)
                     && io_buffer_full;
  assign new_stall = (slb_addr[17:16] == IO_ADDR_HI)
                     && io_buffer_full;

  assign mem_wr = wr_q & rdy_in;

  // RAM answers one cycle late: in step k it returns byte k-1.
  always_comb begin
    raw_n = raw_q;
    if (step != 3'd0) raw_n[{lane, 3'b000} +: 8] = mem_din;
  end

  mem_load_ext u_ext (
    .raw  (raw_n),
    .size (req_size),
    .sgn  (req_sgn),
    .data (ext_data)
  );

  always_comb begin
    state_n = state;
    unique case (state)
      ST_IDLE: begin
        if (grant_if || (grant_slb && !slb_wr))
          state_n = ST_READ;
        else if (grant_slb)
          state_n = ST_WRITE;
      end
      ST_READ: begin
        if (clear_in || rd_last) state_n = ST_IDLE;
      end
      ST_WRITE: begin
        if (wr_last) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) state <= ST_IDLE;
    else if (rdy_in) state <= state_n;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      last_slb      <= 1'b1;
      is_fetch      <= 1'b0;
      req_addr      <= '0;
      req_data      <= '0;
      req_n         <= '0;
      req_size      <= '0;
      req_sgn       <= 1'b0;
      req_entry     <= '0;
      step          <= '0;
      raw_q         <= '0;
      wr_q          <= 1'b0;
      if_done       <= 1'b0;
      if_data       <= '0;
      slb_done      <= 1'b0;
      slb_entry_out <= '0;
      slb_din       <= '0;
      mem_a         <= '0;
      mem_dout      <= '0;
    end else if (rdy_in) begin
      if_done  <= 1'b0;
      slb_done <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (grant_if || grant_slb) begin
            step     <= '0;
            raw_q    <= '0;
            last_slb <= grant_slb;
            mem_a    <= grant_if ? if_addr : slb_addr;
            req_addr <= grant_if ? if_addr : slb_addr;
          end
          if (grant_if) begin
            is_fetch <= 1'b1;
            req_n    <= 3'd4;
            req_size <= SZ_W;
            req_sgn  <= 1'b0;
            wr_q     <= 1'b0;
          end else if (grant_slb) begin
            is_fetch  <= 1'b0;
            req_n     <= size_bytes(slb_size);
            req_size  <= slb_size;
            req_sgn   <= slb_signed;
            req_data  <= slb_dout;
            req_entry <= slb_entry;
            mem_dout  <= slb_dout[7:0];
            wr_q      <= slb_wr && !new_stall;
          end
        end
        ST_READ: begin
          // A rollback drops the read with mem_a left where it was.
          if (!clear_in) begin
            if (step != 3'd0) raw_q <= raw_n;
            if (rd_last) begin
              if (is_fetch) begin
                if_done <= 1'b1;
                if_data <= ext_data;
              end else begin
                slb_done      <= 1'b1;
                slb_entry_out <= req_entry;
                slb_din       <= ext_data;
              end
            end else begin
              step <= step_p1;
              if (step_p1 < req_n) mem_a <= addr_nxt;
            end
          end
        end
        ST_WRITE: begin
          if (wr_last) begin
            wr_q          <= 1'b0;
            slb_done      <= 1'b1;
            slb_entry_out <= req_entry;
            slb_din       <= '0;
          end else if (wr_q) begin
            step     <= step_p1;
            mem_a    <= addr_nxt;
            mem_dout <= byte_nxt;
            wr_q     <= !stall;
          end else begin
            wr_q <= !stall;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl: directed scenarios plus random
// loads, stores and fetches against a byte-array memory model.
module tb_mem_ctrl;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        clear_in;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_done;
  logic [31:0] if_data;
  logic        slb_need;
  logic        slb_wr;
  logic [31:0] slb_addr;
  logic [1:0]  slb_size;
  logic        slb_signed;
  logic [31:0] slb_dout;
  logic [3:0]  slb_entry;
  logic        slb_done;
  logic [3:0]  slb_entry_out;
  logic [31:0] slb_din;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full;

  mem_ctrl #(.ENTRY_W(4)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .clear_in(clear_in), .if_req(if_req), .if_addr(if_addr),
    .if_done(if_done), .if_data(if_data),
    .slb_need(slb_need), .slb_wr(slb_wr), .slb_addr(slb_addr),
    .slb_size(slb_size), .slb_signed(slb_signed),
    .slb_dout(slb_dout), .slb_entry(slb_entry),
    .slb_done(slb_done), .slb_entry_out(slb_entry_out),
    .slb_din(slb_din), .mem_din(mem_din), .mem_dout(mem_dout),
    .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full)
  );

  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  entry;
    int          cyc;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  data;
  } wr_t;

  exp_t fq[$];
  exp_t sq[$];
  wr_t  wq[$];

  logic [7:0] phys [0:65535];
  logic [7:0] refm [0:65535];

  function automatic logic [15:0] idx(logic [31:0] a);
    return a[15:0];
  endfunction

  function automatic logic [31:0] ld_ref(logic [31:0] a,
                                         logic [1:0] sz, bit sg);
    int n;
    logic [31:0] v;
    n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    v = 32'd0;
    for (int i = 0; i < n; i++)
      v |= 32'(refm[idx(a + i)]) << (8 * i);
    if (sg && n < 4 && v[8*n-1]) v |= 32'hFFFF_FFFF << (8 * n);
    return v;
  endfunction

  task automatic check(string nm, logic [31:0] act,
                       logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // RAM stalls together with the rest of the system on rdy_in.
  always @(posedge clk_in) begin
    if (rdy_in) begin
      mem_din <= phys[idx(mem_a)];
      if (mem_wr) phys[idx(mem_a)] <= mem_dout;
    end
  end

  always @(negedge clk_in) begin : mon
    exp_t e;
    wr_t  w;
    if (if_done) begin
      n_chk++;
      if (fq.size() == 0) begin
        n_fail++;
        $display("FAIL if_unexp: got if_done data %h expected none",
                 if_data);
      end else begin
        n_chk--;
        e = fq.pop_front();
        check("if_data", if_data, e.data);
        check("if_cycle", cyc, e.cyc);
      end
    end
    if (slb_done) begin
      n_chk++;
      if (sq.size() == 0) begin
        n_fail++;
        $display("FAIL slb_unexp: got slb_done data %h expected none",
                 slb_din);
      end else begin
        n_chk--;
        e = sq.pop_front();
        check("slb_din", slb_din, e.data);
        check("slb_entry", {28'd0, slb_entry_out}, {28'd0, e.entry});
        check("slb_cycle", cyc, e.cyc);
      end
    end
    if (mem_wr) begin
      n_chk++;
      if (wq.size() == 0) begin
        n_fail++;
        $display("FAIL wr_unexp: got write %h@%h expected none",
                 mem_dout, mem_a);
      end else begin
        n_chk--;
        w = wq.pop_front();
        check("wr_addr", mem_a, w.addr);
        check("wr_data", {24'd0, mem_dout}, {24'd0, w.data});
      end
    end
  end

  task automatic wait_done(bit is_slb);
    int t;
    t = 0;
    do begin
      @(posedge clk_in); #1;
      t++;
    end while (!(is_slb ? slb_done : if_done) && t < 60);
    if (t >= 60) begin
      n_chk++;
      n_fail++;
      $display("FAIL timeout: got no done after %0d cycles expected done",
               t);
    end
  endtask

  task automatic fetch(logic [31:0] a, int extra);
    exp_t e;
    e.data  = ld_ref(a, 2'd2, 1'b0);
    e.entry = 4'd0;
    e.cyc   = cyc + extra + 6;
    fq.push_back(e);
    if_req  = 1'b1;
    if_addr = a;
    wait_done(1'b0);
    if_req = 1'b0;
    @(posedge clk_in); #1;
  endtask

  task automatic slb_op(bit wr, logic [31:0] a, logic [1:0] sz,
                        bit sg, logic [31:0] d, logic [3:0] ent,
                        int extra, int stalls);
    exp_t e;
    wr_t  w;
    int   n;
    n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    e.entry = ent;
    if (wr) begin
      for (int i = 0; i < n; i++) begin
        w.addr = a + i;
        w.data = d[8*i +: 8];
        wq.push_back(w);
        refm[idx(a + i)] = d[8*i +: 8];
      end
      e.data = 32'd0;
      e.cyc  = cyc + extra + 1 + n + stalls;
    end else begin
      e.data = ld_ref(a, sz, sg);
      e.cyc  = cyc + extra + 2 + n;
    end
    sq.push_back(e);
    slb_need   = 1'b1;
    slb_wr     = wr;
    slb_addr   = a;
    slb_size   = sz;
    slb_signed = sg;
    slb_dout   = d;
    slb_entry  = ent;
    wait_done(1'b1);
    slb_need = 1'b0;
    @(posedge clk_in); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test expected $finish");
    $fatal(1);
  end

  initial begin
    int          k;
    logic [31:0] a;
    wr_t         w;
    for (int i = 0; i < 65536; i++) begin
      phys[i] = 8'(i) ^ 8'(i >> 8) ^ 8'h5A;
      refm[i] = 8'(i) ^ 8'(i >> 8) ^ 8'h5A;
    end
    rst_in = 1'b1; rdy_in = 1'b1; clear_in = 1'b0;
    if_req = 1'b0; if_addr = '0; slb_need = 1'b0; slb_wr = 1'b0;
    slb_addr = '0; slb_size = '0; slb_signed = 1'b0;
    slb_dout = '0; slb_entry = '0; io_buffer_full = 1'b0;
    repeat (2) @(posedge clk_in);
    #1;
    check("rst_if_done", {31'd0, if_done}, 32'd0);
    check("rst_slb_done", {31'd0, slb_done}, 32'd0);
    check("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
    check("rst_mem_a", mem_a, 32'd0);
    check("rst_if_data", if_data, 32'd0);
    check("rst_slb_din", slb_din, 32'd0);
    rst_in = 1'b0;
    @(posedge clk_in); #1;

    phys[16'h100] = 8'h13; refm[16'h100] = 8'h13;
    phys[16'h101] = 8'h37; refm[16'h101] = 8'h37;
    phys[16'h102] = 8'hBE; refm[16'h102] = 8'hBE;
    phys[16'h103] = 8'hEF; refm[16'h103] = 8'hEF;
    phys[16'h020] = 8'h80; refm[16'h020] = 8'h80;
    fetch(32'h100, 0);
    slb_op(1'b0, 32'h20, 2'd0, 1'b1, 32'd0, 4'd5, 0, 0);
    slb_op(1'b0, 32'h20, 2'd0, 1'b0, 32'd0, 4'd6, 0, 0);
    slb_op(1'b1, 32'h41, 2'd1, 1'b0, 32'h0000_ABCD, 4'd7, 0, 0);
    slb_op(1'b0, 32'h41, 2'd1, 1'b0, 32'd0, 4'd8, 0, 0);

    io_buffer_full = 1'b1;
    fork
      slb_op(1'b1, 32'h0003_0000, 2'd0, 1'b0, 32'h5C, 4'd9, 0, 3);
      begin
        repeat (3) begin @(posedge clk_in); #1; end
        io_buffer_full = 1'b0;
      end
    join

    // last grant is slb: fetch wins, then slb right after the pulse
    for (int r = 0; r < 2; r++) begin
      fork
        fetch(32'h104 + 4 * r, 0);
        slb_op(1'b0, 32'h108 + r, 2'd1, 1'b1, 32'd0, 4'(r + 1), 7, 0);
      join
    end
    fetch(32'h120, 0);
    fork
      fetch(32'h124, 3 + 4);
      slb_op(1'b0, 32'h130, 2'd2, 1'b0, 32'd0, 4'd3, 0, 0);
    join

    if_req = 1'b1; if_addr = 32'h300;
    repeat (3) begin @(posedge clk_in); #1; end
    clear_in = 1'b1; if_req = 1'b0;
    @(posedge clk_in); #1;
    clear_in = 1'b0;
    check("clr_no_done", {31'd0, if_done}, 32'd0);
    fetch(32'h304, 0);

    fork
      slb_op(1'b1, 32'h400, 2'd2, 1'b0, 32'h1122_3344, 4'd10, 0, 0);
      begin
        repeat (2) begin @(posedge clk_in); #1; end
        clear_in = 1'b1;
        @(posedge clk_in); #1;
        clear_in = 1'b0;
      end
    join
    slb_op(1'b0, 32'h400, 2'd2, 1'b0, 32'd0, 4'd11, 0, 0);

    w.addr = 32'h500; w.data = 8'hA1;
    wq.push_back(w);
    refm[16'h500] = 8'hA1;
    slb_need = 1'b1; slb_wr = 1'b1; slb_addr = 32'h500;
    slb_size = 2'd2; slb_dout = 32'hD4C3_B2A1; slb_entry = 4'd12;
    repeat (2) begin @(posedge clk_in); #1; end
    #2;
    rst_in = 1'b1;
    #1;
    check("arst_mem_wr", {31'd0, mem_wr}, 32'd0);
    check("arst_slb_done", {31'd0, slb_done}, 32'd0);
    slb_need = 1'b0;
    @(posedge clk_in); #1;
    rst_in = 1'b0;
    @(posedge clk_in); #1;
    slb_op(1'b0, 32'h500, 2'd2, 1'b0, 32'd0, 4'd13, 0, 0);

    fork
      slb_op(1'b0, 32'h100, 2'd2, 1'b0, 32'd0, 4'd14, 2, 0);
      begin
        repeat (2) begin @(posedge clk_in); #1; end
        rdy_in = 1'b0;
        repeat (2) begin @(posedge clk_in); #1; end
        rdy_in = 1'b1;
      end
    join

    slb_op(1'b0, 32'hFFFF_FFFE, 2'd2, 1'b0, 32'd0, 4'd15, 0, 0);
    slb_op(1'b0, 32'hFFFF_FFFF, 2'd1, 1'b1, 32'd0, 4'd1, 0, 0);

    for (int i = 0; i < 40; i++) begin
      k = $urandom_range(0, 3);
      a = 32'h1000 + $urandom_range(0, 255);
      if (k == 0)
        fetch(a, 0);
      else
        slb_op(k == 1, a, 2'($urandom_range(0, 3)),
               1'($urandom_range(0, 1)), $urandom,
               4'($urandom_range(0, 15)), 0, 0);
    end

    repeat (5) @(posedge clk_in);
    #1;
    check("fq_empty", fq.size(), 32'd0);
    check("sq_empty", sq.size(), 32'd0);
    check("wq_empty", wq.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
